regfile_param: RTL and testbench
================================

REGFILE_PARAM -- requirements
Module: regfile_param

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data width in bits; legal values are multiples of 8 and at least 8.
REQ-002 SHALL have parameter DEPTH, default 32: number of entries; legal values are 2..256.
REQ-003 SHALL have parameter ZERO_REG, default 1: 1 hardwires entry 0 to zero.
REQ-004 SHALL have parameter BYPASS, default 1: 1 enables write-to-read forwarding.
REQ-005 SHALL have localparam AW = clog2(DEPTH) and localparam NB = WIDTH/8.
REQ-006 SHALL have these ports (name, direction, width, meaning):
- Clk  in  1  clock, positive edge.
- ResetN  in  1  reset, asynchronous, active-low.
- ReadRegister1  in  AW  port-1 read address.
- ReadRegister2  in  AW  port-2 read address.
- ReadData1  out  WIDTH  port-1 read data, asynchronous.
- ReadData2  out  WIDTH  port-2 read data, asynchronous.
- WriteRegister  in  AW  write address.
- WriteData  in  WIDTH  write data.
- RegWrite  in  1  write request.
- ByteEn  in  NB  per-byte write enable; bit k covers bits 8k+7..8k.
- Clear  in  1  request a full-array clear sweep.
- Ready  out  1  high when a write is accepted.
- ClearDone  out  1  one-cycle pulse at the end of a sweep.

Function
REQ-007 SHALL perform a write at the rising edge of Clk when RegWrite=1 and Ready=1, updating only the bytes whose ByteEn bit is 1.
REQ-008 SHALL drop a write if WriteRegister>=DEPTH, or if WriteRegister=0 and ZERO_REG=1.
REQ-009 SHALL make reads combinational from the stored contents, returning 0 for an address >=DEPTH and 0 for address 0 when ZERO_REG=1.
REQ-010 SHALL, when BYPASS=1, forward data on a same-cycle read of the address being written: if a write is accepted this cycle, is not dropped, and ReadRegisterN=WriteRegister, then ReadDataN equals the stored word with the enabled bytes replaced by WriteData.
REQ-011 SHALL, when BYPASS=0, return pre-write contents on a same-cycle read; the new value becomes visible after the edge.
REQ-012 SHALL implement a two-state FSM with states IDLE and SWEEP.
REQ-013 SHALL move IDLE->SWEEP on the edge where Clear=1, loading the sweep counter to 0.
REQ-014 SHALL, in SWEEP, zero the entry addressed by the counter at each edge and then increment the counter.
REQ-015 SHALL move SWEEP->IDLE on the edge that zeroes entry DEPTH-1.
REQ-016 SHALL drive ClearDone=1 for exactly the one cycle after that edge.
REQ-017 SHALL make a sweep take exactly DEPTH cycles.
REQ-018 SHALL hold Ready=1 in IDLE and Ready=0 in SWEEP.
REQ-019 SHALL ignore RegWrite in SWEEP (no write, no bypass).
REQ-020 SHALL ignore Clear asserted during SWEEP; it neither restarts nor extends the sweep.
REQ-021 SHALL, when Clear=1 and an accepted write occur in the same IDLE cycle, perform the write, start the sweep next cycle, and let the sweep zero that entry.
REQ-022 SHALL allow reads during SWEEP; entries below the counter read 0, the others read their old contents.

Reset
REQ-023 SHALL, on ResetN=0, asynchronously clear all entries to 0, set state=IDLE, counter=0 and ClearDone=0; Ready=1 follows from IDLE.
REQ-024 SHALL, on reset asserted mid-sweep, abort the sweep immediately with no ClearDone pulse.
REQ-025 SHALL treat the first edge after ResetN rises as a normal IDLE cycle.

Structure
REQ-026 SHALL place the state encoding (IDLE, SWEEP) and the byte-merge width constant in a shared package, regfile_pkg.
REQ-027 SHALL use one sub-module, regfile_bytemerge (old word, new word, ByteEn -> merged word), instantiated once for the write path and once per read port for bypass.
REQ-028 SHALL build both read ports from one common read-mux description.

Verification (WIDTH=32, DEPTH=32 unless noted)
REQ-029 SHALL cover byte-enable write: write 0xAABBCCDD to r5 with ByteEn=1111, then 0x11223344 with ByteEn=0101 -> r5 reads 0xAA22CC44.
REQ-030 SHALL cover the zero register: write 0xFFFFFFFF to r0 -> r0 reads 0; with ZERO_REG=0 -> reads 0xFFFFFFFF.
REQ-031 SHALL cover bypass: r7=0x12345678, write 0x0000FFFF with ByteEn=0011 and ReadRegister1=7 in the same cycle -> ReadData1=0x1234FFFF before the edge (BYPASS=1), 0x12345678 before the edge (BYPASS=0).
REQ-032 SHALL cover a sweep: fill all entries with nonzero values, pulse Clear -> Ready=0 for 32 cycles, ClearDone pulses once, all reads return 0, and writes attempted during the sweep are lost.
REQ-033 SHALL cover a write coincident with Clear: write 0x5 to r31 in the Clear cycle -> r31 reads 5 until its sweep slot, then 0.
REQ-034 SHALL cover reset mid-sweep: ResetN=0 at sweep cycle 10 -> all entries 0 and Ready=1 immediately, no ClearDone; with DEPTH=20, address 25 reads 0 and writes to it are dropped.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and constants for the parameterised register file.
package regfile_pkg;

   // Clear-sweep controller states
   typedef enum logic {
      IDLE  = 1'b0,
      SWEEP = 1'b1
   } state_t;

   // Width of one byte lane handled by the byte-merge unit
   localparam int unsigned BYTE_W = 8;

endpackage

// File: rtl/regfile_bytemerge.sv
// Byte-lane merge: replaces the enabled bytes of old_word with new_word.
module regfile_bytemerge
   import regfile_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH-1:0]        old_word,
   input  logic [WIDTH-1:0]        new_word,
   input  logic [WIDTH/BYTE_W-1:0] byte_en,
   output logic [WIDTH-1:0]        merged
);

   // Select each byte lane from the new word when its enable bit is set
   always_comb begin
      merged = old_word;
      for (int unsigned k = 0; k < WIDTH / BYTE_W; k++) begin
         if (byte_en[k]) begin
            merged[k*BYTE_W +: BYTE_W] = new_word[k*BYTE_W +: BYTE_W];
         end
      end
   end

endmodule

// File: rtl/regfile_param.sv
// Two-read / one-write register file with byte enables, optional hardwired
// zero entry, optional write-to-read forwarding and a full-array clear sweep.
module regfile_param
   import regfile_pkg::*;
#(
   parameter  int unsigned WIDTH    = 32,
   parameter  int unsigned DEPTH    = 32,
   parameter  int unsigned ZERO_REG = 1,
   parameter  int unsigned BYPASS   = 1,
   localparam int unsigned AW       = $clog2(DEPTH),
   localparam int unsigned NB       = WIDTH / 8
) (
   input  logic             Clk,
   input  logic             ResetN,
   input  logic [AW-1:0]    ReadRegister1,
   input  logic [AW-1:0]    ReadRegister2,
   output logic [WIDTH-1:0] ReadData1,
   output logic [WIDTH-1:0] ReadData2,
   input  logic [AW-1:0]    WriteRegister,
   input  logic [WIDTH-1:0] WriteData,
   input  logic             RegWrite,
   input  logic [NB-1:0]    ByteEn,
   input  logic             Clear,
   output logic             Ready,
   output logic             ClearDone
);

   state_t           state;
   state_t           state_next;
   logic [AW-1:0]    cnt;
   logic [AW-1:0]    cnt_next;
   logic             done_next;
   logic [WIDTH-1:0] mem [DEPTH];

   logic             wr_ok;
   logic [WIDTH-1:0] wr_old;
   logic [WIDTH-1:0] wr_new;

   // Address lies inside the populated part of the array
   function automatic logic addr_ok(input logic [AW-1:0] a);
      return 32'(a) < 32'(DEPTH);
   endfunction

   // Address reads as zero: out of range, or the hardwired zero entry
   function automatic logic addr_zero(input logic [AW-1:0] a);
      return !addr_ok(a) || ((ZERO_REG != 0) && (a == '0));
   endfunction

   assign Ready = (state == IDLE);

   // Write accepted only in IDLE, to a legal, writable entry
   assign wr_ok = RegWrite && Ready && !addr_zero(WriteRegister);

   // Current contents of the write target, used as the merge base
   always_comb begin
      wr_old = '0;
      if (addr_ok(WriteRegister)) begin
         wr_old = mem[WriteRegister];
      end
   end

   regfile_bytemerge #(.WIDTH(WIDTH)) u_wr_merge (
      .old_word (wr_old),
      .new_word (WriteData),
      .byte_en  (ByteEn),
      .merged   (wr_new)
   );

   // Both read ports come from one mux description; the bypass merge uses
   // the port's own stored word, which equals wr_old whenever the port hits.
   logic [AW-1:0]    rd_addr [2];
   logic [WIDTH-1:0] rd_data [2];

   assign rd_addr[0] = ReadRegister1;
   assign rd_addr[1] = ReadRegister2;

   for (genvar p = 0; p < 2; p++) begin : g_rd
      logic [WIDTH-1:0] stored;
      logic [WIDTH-1:0] fwd;
      logic             hit;

      // Stored word, forced to zero for unreadable addresses
      always_comb begin
         stored = '0;
         if (!addr_zero(rd_addr[p])) begin
            stored = mem[rd_addr[p]];
         end
      end

      regfile_bytemerge #(.WIDTH(WIDTH)) u_rd_merge (
         .old_word (stored),
         .new_word (WriteData),
         .byte_en  (ByteEn),
         .merged   (fwd)
      );

      assign hit        = (BYPASS != 0) && wr_ok && (rd_addr[p] == WriteRegister);
      assign rd_data[p] = hit ? fwd : stored;
   end

   assign ReadData1 = rd_data[0];
   assign ReadData2 = rd_data[1];

   // Array storage: async clear, sweep zeroing, or accepted byte write
   always_ff @(posedge Clk or negedge ResetN) begin
      if (!ResetN) begin
         mem <= '{default: '0};
      end else if (state == SWEEP) begin
         mem[cnt] <= '0;
      end else if (wr_ok) begin
         mem[WriteRegister] <= wr_new;
      end
   end

   // Controller state, sweep counter and done pulse registers
   always_ff @(posedge Clk or negedge ResetN) begin
      if (!ResetN) begin
         state     <= IDLE;
         cnt       <= '0;
         ClearDone <= 1'b0;
      end else begin
         state     <= state_next;
         cnt       <= cnt_next;
         ClearDone <= done_next;
      end
   end

   // Next-state logic: start on Clear in IDLE, finish after entry DEPTH-1
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      done_next  = 1'b0;
      case (state)
         IDLE: begin
            if (Clear) begin
               state_next = SWEEP;
               cnt_next   = '0;
            end
         end
         SWEEP: begin
            if (cnt == AW'(DEPTH - 1)) begin
               state_next = IDLE;
               cnt_next   = '0;
               done_next  = 1'b1;
            end else begin
               cnt_next = cnt + AW'(1);
            end
         end
         default: begin
            state_next = IDLE;
            cnt_next   = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench: three register-file configurations share one stimulus
// stream and are compared every cycle against a behavioural array model.
module tb_regfile_param;

   logic        Clk = 1'b0;
   logic        ResetN;
   logic [4:0]  rr1, rr2, wa;
   logic [31:0] wd;
   logic        rw;
   logic [3:0]  be;
   logic        clr;

   logic [31:0] rd1 [3];
   logic [31:0] rd2 [3];
   logic        rdy [3];
   logic        cdn [3];

   always #5 Clk = ~Clk;

   // u0: defaults; u1: no zero entry, no bypass; u2: DEPTH=20
   regfile_param u0 (
      .Clk(Clk), .ResetN(ResetN), .ReadRegister1(rr1), .ReadRegister2(rr2),
      .ReadData1(rd1[0]), .ReadData2(rd2[0]), .WriteRegister(wa), .WriteData(wd),
      .RegWrite(rw), .ByteEn(be), .Clear(clr), .Ready(rdy[0]), .ClearDone(cdn[0]));

   regfile_param #(.ZERO_REG(0), .BYPASS(0)) u1 (
      .Clk(Clk), .ResetN(ResetN), .ReadRegister1(rr1), .ReadRegister2(rr2),
      .ReadData1(rd1[1]), .ReadData2(rd2[1]), .WriteRegister(wa), .WriteData(wd),
      .RegWrite(rw), .ByteEn(be), .Clear(clr), .Ready(rdy[1]), .ClearDone(cdn[1]));

   regfile_param #(.DEPTH(20)) u2 (
      .Clk(Clk), .ResetN(ResetN), .ReadRegister1(rr1), .ReadRegister2(rr2),
      .ReadData1(rd1[2]), .ReadData2(rd2[2]), .WriteRegister(wa), .WriteData(wd),
      .RegWrite(rw), .ByteEn(be), .Clear(clr), .Ready(rdy[2]), .ClearDone(cdn[2]));

   // Reference model state per configuration
   int          depth_c [3] = '{32, 32, 20};
   bit          zr_c    [3] = '{1, 0, 1};
   bit          bp_c    [3] = '{1, 0, 1};
   logic [31:0] m    [3][32];
   bit          swp  [3];
   int          pos  [3];
   bit          done [3];

   int n_checks = 0;
   int n_fail   = 0;

   function automatic logic [31:0] merge_bytes(logic [31:0] o, logic [31:0] n, logic [3:0] e);
      logic [31:0] r = o;
      for (int k = 0; k < 4; k++) if (e[k]) r[8*k +: 8] = n[8*k +: 8];
      return r;
   endfunction

   function automatic bit accepts(int i);
      return rw && !swp[i] && (int'(wa) < depth_c[i]) && !(wa == 0 && zr_c[i]);
   endfunction

   function automatic logic [31:0] exp_rd(int i, logic [4:0] a);
      logic [31:0] v;
      if (int'(a) >= depth_c[i] || (a == 0 && zr_c[i])) return 32'h0;
      v = m[i][a];
      if (bp_c[i] && accepts(i) && a == wa) v = merge_bytes(v, wd, be);
      return v;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         for (int a = 0; a < 32; a++) m[i][a] = 32'h0;
         swp[i] = 0; pos[i] = 0; done[i] = 0;
      end
   endtask

   task automatic model_edge();
      for (int i = 0; i < 3; i++) begin
         if (swp[i]) begin
            m[i][pos[i]] = 32'h0;
            pos[i]++;
            done[i] = (pos[i] == depth_c[i]);
            if (done[i]) swp[i] = 0;
         end else begin
            if (accepts(i)) m[i][wa] = merge_bytes(m[i][wa], wd, be);
            if (clr) begin swp[i] = 1; pos[i] = 0; end
            done[i] = 0;
         end
      end
   endtask

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all(string ctx);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("%s u%0d rd1[%0d]", ctx, i, rr1), rd1[i], exp_rd(i, rr1));
         chk($sformatf("%s u%0d rd2[%0d]", ctx, i, rr2), rd2[i], exp_rd(i, rr2));
         chk($sformatf("%s u%0d ready", ctx, i), 32'(rdy[i]), 32'(!swp[i]));
         chk($sformatf("%s u%0d cleardone", ctx, i), 32'(cdn[i]), 32'(done[i]));
      end
   endtask

   // One clock cycle: check settled outputs, take the edge, return at negedge
   task automatic step(string ctx);
      #1 check_all(ctx);
      @(posedge Clk);
      model_edge();
      @(negedge Clk);
   endtask

   task automatic drive(logic w, logic [4:0] a, logic [31:0] d, logic [3:0] e,
                        logic c, logic [4:0] r1, logic [4:0] r2);
      rw = w; wa = a; wd = d; be = e; clr = c; rr1 = r1; rr2 = r2;
   endtask

   int n_low0, n_low2, n_pulse0, n_pulse2;

   initial begin
      ResetN = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0);
      model_reset();
      @(negedge Clk);
      #1 check_all("reset");
      drive(0, 0, 0, 0, 0, 5, 31);
      #1 check_all("reset_rd");
      @(negedge Clk);
      ResetN = 1'b1;

      // Byte-enable write
      drive(1, 5, 32'hAABBCCDD, 4'b1111, 0, 5, 0); step("be_w1");
      drive(1, 5, 32'h11223344, 4'b0101, 0, 5, 5); step("be_w2");
      drive(0, 0, 0, 0, 0, 5, 5); #1;
      chk("r5_bytemerge", rd1[0], 32'hAA22CC44);
      step("be_rd");

      // Zero entry
      drive(1, 0, 32'hFFFFFFFF, 4'b1111, 0, 0, 0); step("r0_w");
      drive(0, 0, 0, 0, 0, 0, 0); #1;
      chk("r0_zero_reg1", rd1[0], 32'h0);
      chk("r0_zero_reg0", rd1[1], 32'hFFFFFFFF);
      step("r0_rd");

      // Bypass versus pre-write data
      drive(1, 7, 32'h12345678, 4'b1111, 0, 0, 0); step("r7_w");
      drive(1, 7, 32'h0000FFFF, 4'b0011, 0, 7, 7); #1;
      chk("bypass_on", rd1[0], 32'h1234FFFF);
      chk("bypass_off", rd1[1], 32'h12345678);
      step("bypass");
      drive(0, 0, 0, 0, 0, 7, 7); #1;
      chk("after_edge_u0", rd1[0], 32'h1234FFFF);
      chk("after_edge_u1", rd1[1], 32'h1234FFFF);
      step("bypass_after");

      // Out-of-range address on the DEPTH=20 instance
      drive(1, 25, 32'hDEADBEEF, 4'b1111, 0, 25, 25); #1;
      chk("oor_bypass_u2", rd1[2], 32'h0);
      step("oor_w");
      drive(0, 0, 0, 0, 0, 25, 25); #1;
      chk("oor_rd_u2", rd1[2], 32'h0);
      chk("oor_rd_u0", rd1[0], 32'hDEADBEEF);
      step("oor_rd");

      // Randomised traffic with occasional Clear
      for (int n = 0; n < 300; n++) begin
         drive($urandom_range(0, 1), 5'($urandom), $urandom, 4'($urandom),
               ($urandom_range(0, 39) == 0), 5'($urandom), 5'($urandom));
         step("random");
      end
      drive(0, 0, 0, 0, 0, 0, 0);
      for (int n = 0; n < 34; n++) step("drain");

      // Fill every entry, then Clear coincident with a write of 5 to r31
      for (int a = 0; a < 32; a++) begin
         drive(1, 5'(a), $urandom | 32'h1, 4'b1111, 0, 5'($urandom), 5'($urandom));
         step("fill");
      end
      drive(1, 31, 32'h5, 4'b1111, 1, 31, 0); step("clear_w31");
      n_low0 = !rdy[0]; n_low2 = !rdy[2];
      n_pulse0 = cdn[0]; n_pulse2 = cdn[2];
      chk("r31_before_slot", rd1[0], 32'h5);
      for (int n = 0; n < 36; n++) begin
         drive(n < 32, 5'($urandom), $urandom, 4'($urandom), (n < 15) && $urandom_range(0, 1),
               31, 5'($urandom));
         step("sweep");
         n_low0 += !rdy[0]; n_low2 += !rdy[2];
         n_pulse0 += cdn[0]; n_pulse2 += cdn[2];
      end
      chk("ready_low_cycles_u0", 32'(n_low0), 32'd32);
      chk("ready_low_cycles_u2", 32'(n_low2), 32'd20);
      chk("cleardone_pulses_u0", 32'(n_pulse0), 32'd1);
      chk("cleardone_pulses_u2", 32'(n_pulse2), 32'd1);
      for (int a = 0; a < 32; a++) begin
         drive(0, 0, 0, 0, 0, 5'(a), 5'(31 - a)); #1;
         chk($sformatf("swept_r%0d", a), rd1[0], 32'h0);
         step("swept_rd");
      end

      // Reset asserted in the middle of a sweep
      for (int a = 1; a < 32; a++) begin
         drive(1, 5'(a), $urandom | 32'h1, 4'b1111, 0, 0, 0); step("refill");
      end
      drive(0, 0, 0, 0, 1, 0, 0); step("clear2");
      drive(0, 0, 0, 0, 0, 20, 31);
      for (int n = 0; n < 10; n++) step("sweep2");
      ResetN = 1'b0;
      #1 model_reset();
      check_all("mid_sweep_reset");
      chk("mid_reset_ready", 32'(rdy[0]), 32'd1);
      chk("mid_reset_r31", rd2[0], 32'h0);
      @(negedge Clk);
      @(negedge Clk);
      ResetN = 1'b1;
      for (int n = 0; n < 3; n++) step("post_reset");
      drive(1, 9, 32'hCAFEF00D, 4'b1111, 0, 9, 0); step("post_reset_w");
      drive(0, 0, 0, 0, 0, 9, 0); #1;
      chk("post_reset_r9", rd1[0], 32'hCAFEF00D);
      step("post_reset_rd");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
